// File: rtl/pr_write_packer_pkg.sv
// Shared constants and types for the PageRank rank-writeback packer.
package pr_write_packer_pkg;

    localparam int INT_W  = 64;
    localparam int LINE_W = 512;
    localparam int LANES  = LINE_W / INT_W;
    localparam int STRB_W = LINE_W / 8;
    localparam int SLOT_W = $clog2(LANES) + 1;
    localparam int ADDR_W = 64;
    localparam int ID_W   = 16;
    localparam int OUTS_W = 3;

    localparam logic [SLOT_W-1:0] LANES_SLOT = SLOT_W'(LANES);

    // AXI ID map shared by the engine's masters
    localparam logic [ID_W-1:0] AXI_ID_VERTEX     = 16'd0;
    localparam logic [ID_W-1:0] AXI_ID_IN_EDGE    = 16'd1;
    localparam logic [ID_W-1:0] AXI_ID_RANK_READ  = 16'd2;
    localparam logic [ID_W-1:0] AXI_ID_RANK_WRITE = 16'd3;
    localparam logic [ID_W-1:0] AXI_ID            = AXI_ID_RANK_WRITE;

    localparam logic [OUTS_W-1:0] MAX_OUTS      = 3'd4;
    localparam logic [2:0]        AXI_SIZE_64B  = 3'b110;
    localparam logic [1:0]        AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [STRB_W-1:0] lane_strb(input logic [SLOT_W-1:0] filled);
        logic [STRB_W-1:0] strb;
        strb = {STRB_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(filled)) begin
                strb[k*8 +: 8] = 8'hFF;
            end else begin
                strb[k*8 +: 8] = 8'h00;
            end
        end
        return strb;
    endfunction

endpackage

// File: rtl/pr_write_packer_if.sv
// Rank word stream plus single-beat AXI write channels of the rank writeback stage.
interface pr_write_packer_if;
    import pr_write_packer_pkg::*;

    logic              in_valid;
    logic [INT_W-1:0]  in_data;
    logic              in_ready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [LINE_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  in_valid, in_data, awready, wready, bid, bresp, bvalid,
        output in_ready, awid, awaddr, awlen, awsize, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready
    );

    modport slave (
        output in_valid, in_data, awready, wready, bid, bresp, bvalid,
        input  in_ready, awid, awaddr, awlen, awsize, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready
    );

endinterface

// File: rtl/pr_write_packer.sv
// Packs the per-vertex rank stream into 512-bit lines and writes each line as a
// single-beat AXI burst, limiting lines in flight and reporting round completion.
module pr_write_packer
    import pr_write_packer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [63:0]         n_values,
    output logic                busy,
    output logic                done,
    output logic                err,
    pr_write_packer_if.master   bus
);

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [63:0]         remaining_q, remaining_d;
    logic [63:0]         line_idx_q, line_idx_d;
    logic [OUTS_W-1:0]   outs_q, outs_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                in_fire_s;
    logic                aw_hs_s;
    logic                w_hs_s;
    logic                b_hit_s;
    logic [OUTS_W-1:0]   outs_after_b_s;

    assign bus.in_ready = (state_q == S_FILL) && (slot_q < LANES_SLOT) && (remaining_q != 64'd0);
    assign in_fire_s    = bus.in_valid && bus.in_ready;
    assign aw_hs_s      = awvalid_q && bus.awready;
    assign w_hs_s       = wvalid_q && bus.wready;
    // Responses are only meaningful inside a round; stragglers after a reset are dropped.
    assign b_hit_s        = (state_q != S_IDLE) && bus.bvalid && (bus.bid == AXI_ID);
    assign outs_after_b_s = (b_hit_s && (outs_q != 3'd0)) ? (outs_q - 3'd1) : outs_q;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = base_q + (line_idx_q << 6);
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = AXI_SIZE_64B;
    assign bus.awvalid = awvalid_q;
    assign bus.wid     = AXI_ID;
    assign bus.wdata   = line_q;
    assign bus.wstrb   = lane_strb(slot_q);
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = 1'b1;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

    // Next-state, packing, address and outstanding-line bookkeeping
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        remaining_d = remaining_q;
        line_idx_d  = line_idx_q;
        outs_d      = outs_after_b_s;
        base_d      = base_q;
        line_d      = line_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        if (b_hit_s && (bus.bresp != AXI_RESP_OKAY)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base_addr & ~64'h3F;
                    remaining_d = n_values;
                    line_idx_d  = 64'd0;
                    slot_d      = {SLOT_W{1'b0}};
                    line_d      = {LINE_W{1'b0}};
                    err_d       = 1'b0;
                    state_d     = (n_values == 64'd0) ? S_DONE : S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (in_fire_s) begin
                    line_d[slot_q[SLOT_W-2:0]*INT_W +: INT_W] = bus.in_data;
                    slot_d      = slot_q + 4'd1;
                    remaining_d = remaining_q - 64'd1;
                    // Valids are raised with the transition so a full line is on the bus next cycle.
                    if ((slot_d == LANES_SLOT) || (remaining_d == 64'd0)) begin
                        state_d   = S_ISSUE;
                        awvalid_d = (outs_after_b_s < MAX_OUTS);
                        wvalid_d  = (outs_after_b_s < MAX_OUTS);
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_ISSUE: begin
                if (!awvalid_q && !aw_done_q) begin
                    if (outs_after_b_s < MAX_OUTS) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        awvalid_d = 1'b0;
                        wvalid_d  = 1'b0;
                    end
                end else begin
                    if (aw_hs_s) begin
                        awvalid_d  = 1'b0;
                        aw_done_d  = 1'b1;
                        line_idx_d = line_idx_q + 64'd1;
                        outs_d     = outs_after_b_s + 3'd1;
                    end else begin
                        aw_done_d = aw_done_q;
                    end
                    if (w_hs_s) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        w_done_d = w_done_q;
                    end
                    if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                        line_d    = {LINE_W{1'b0}};
                        slot_d    = {SLOT_W{1'b0}};
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = (remaining_q != 64'd0) ? S_FILL : S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DRAIN: begin
                if (outs_after_b_s == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_FILL) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_q      <= {SLOT_W{1'b0}};
            remaining_q <= 64'd0;
            line_idx_q  <= 64'd0;
            outs_q      <= 3'd0;
            base_q      <= 64'd0;
            line_q      <= {LINE_W{1'b0}};
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            remaining_q <= remaining_d;
            line_idx_q  <= line_idx_d;
            outs_q      <= outs_d;
            base_q      <= base_d;
            line_q      <= line_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_pr_write_packer.sv
// Directed bench for pr_write_packer: table of whole rounds plus hand-written
// sequences for AW stall, outstanding-limit stall and mid-round reset.
module tb_pr_write_packer;
    import pr_write_packer_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] base_addr;
    logic [63:0] n_values;
    logic        busy;
    logic        done;
    logic        err;

    pr_write_packer_if bus();

    pr_write_packer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .n_values  (n_values),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory-side responder: records handshakes and returns one B per accepted AW
    logic [63:0]       aw_q[$];
    logic [LINE_W-1:0] wd_q[$];
    logic [STRB_W-1:0] ws_q[$];
    int b_pend = 0, b_cnt = 0, err_at_b = -1, last_b_cyc = -1;
    int outs_model = 0, outs_max = 0;
    bit b_hold = 1'b0, b_one = 1'b0, b_foreign = 1'b0;
    bit awready_en = 1'b1, wready_en = 1'b1;

    initial begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bid     = 16'd0;
        bus.bresp   = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (b_foreign) begin
                bus.bvalid = 1'b1;
                bus.bid    = AXI_ID_RANK_READ;
                bus.bresp  = 2'b10;
                b_foreign  = 1'b0;
            end else if (b_pend > 0 && (!b_hold || b_one)) begin
                bus.bvalid = 1'b1;
                bus.bid    = AXI_ID;
                bus.bresp  = (b_cnt == err_at_b) ? 2'b10 : 2'b00;
                b_pend--;
                b_cnt++;
                b_one      = 1'b0;
                last_b_cyc = cyc_cnt;
                outs_model--;
            end else begin
                bus.bvalid = 1'b0;
            end
            bus.awready = awready_en;
            bus.wready  = wready_en;
            @(negedge clk);
            if (bus.awvalid && bus.awready) begin
                aw_q.push_back(bus.awaddr);
                b_pend++;
                outs_model++;
                if (outs_model > outs_max) outs_max = outs_model;
                chk("aw_fields", 64'({bus.awlen, bus.awsize, bus.awid}), 64'({8'd0, 3'b110, 16'd3}));
            end
            if (bus.wvalid && bus.wready) begin
                wd_q.push_back(bus.wdata);
                ws_q.push_back(bus.wstrb);
                chk("w_fields", 64'({bus.wid, bus.wlast}), 64'({16'd3, 1'b1}));
            end
        end
    end

    typedef struct {
        logic [63:0]       base;
        int                n;
        int                err_line;
        int                exp_lines;
        logic [63:0]       exp_addr0;
        logic [63:0]       exp_addr_last;
        logic [STRB_W-1:0] exp_strb_last;
        logic              exp_err;
    } row_t;

    row_t rows[6];

    task automatic clear_capture();
        aw_q.delete();
        wd_q.delete();
        ws_q.delete();
    endtask

    task automatic start_round(input logic [63:0] base, input logic [63:0] n);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        n_values  = n;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic feed_words(input int n, input logic [63:0] tag, input int first);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 500) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tag + 64'(first + idx);
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk); #1;
            budget++;
        end
        bus.in_valid = 1'b0;
        chk("feed_count", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(output bit seen, output logic err_v, output int dcyc);
        seen  = 1'b0;
        err_v = 1'b0;
        dcyc  = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen  = 1'b1;
                err_v = err;
                dcyc  = cyc_cnt;
            end
            @(posedge clk); #1;
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic chk_lines(input string nm, input int n, input logic [63:0] tag);
        for (int j = 0; j < wd_q.size(); j++) begin
            logic [LINE_W-1:0] e;
            e = {LINE_W{1'b0}};
            for (int k = 0; k < LANES; k++) begin
                if (j*LANES + k < n) e[k*INT_W +: INT_W] = tag + 64'(j*LANES + k);
            end
            chk_line({nm, "_data"}, wd_q[j], e);
        end
    endtask

    task automatic run_row(input row_t r, input logic [63:0] tag, input string nm);
        bit   seen;
        logic err_v;
        int   dcyc;
        clear_capture();
        err_at_b = (r.err_line >= 0) ? (b_cnt + r.err_line) : -1;
        start_round(r.base, 64'(r.n));
        chk({nm, "_busy"}, 64'(busy), 64'(r.n != 0));
        feed_words(r.n, tag, 0);
        wait_done(seen, err_v, dcyc);
        chk({nm, "_aw_count"}, 64'(aw_q.size()), 64'(r.exp_lines));
        chk({nm, "_w_count"}, 64'(wd_q.size()), 64'(r.exp_lines));
        chk({nm, "_err"}, 64'(err_v), 64'(r.exp_err));
        if (r.exp_lines > 0) begin
            chk({nm, "_addr_first"}, aw_q[0], r.exp_addr0);
            chk({nm, "_addr_last"}, aw_q[$], r.exp_addr_last);
            chk({nm, "_strb_last"}, ws_q[$], r.exp_strb_last);
            chk({nm, "_done_after_b"}, 64'(dcyc), 64'(last_b_cyc + 1));
            chk_lines(nm, r.n, tag);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   seen;
        bit   found;
        logic err_v;
        int   dcyc;
        row_t post_rst;

        rows[0] = '{64'h1000, 8,  -1, 1, 64'h1000, 64'h1000, {64{1'b1}},             1'b0};
        rows[1] = '{64'h2040, 11, -1, 2, 64'h2040, 64'h2080, 64'h0000_0000_00FF_FFFF, 1'b0};
        rows[2] = '{64'h3017, 17, -1, 3, 64'h3000, 64'h3080, 64'h0000_0000_0000_00FF, 1'b0};
        rows[3] = '{64'h4000, 16, 1,  2, 64'h4000, 64'h4040, {64{1'b1}},             1'b1};
        rows[4] = '{64'h5000, 0,  -1, 0, 64'h0,    64'h0,    64'h0,                  1'b0};
        rows[5] = '{64'h6000, 3,  -1, 1, 64'h6000, 64'h6000, 64'h0000_0000_00FF_FFFF, 1'b0};
        post_rst = '{64'hA000, 9, -1, 2, 64'hA000, 64'hA040, 64'h0000_0000_0000_00FF, 1'b0};

        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = 64'd0;
        n_values     = 64'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({bus.in_ready, bus.awvalid, bus.wvalid, busy, done, err, bus.bready}),
            64'(7'b0000001));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_row(rows[i], 64'hA5A5_0000_0000_0000 + (64'(i) << 32), $sformatf("row%0d", i));
        end

        // AW held off while W is accepted: AW must stay valid and stable
        clear_capture();
        awready_en = 1'b0;
        start_round(64'h7000, 64'd8);
        feed_words(8, 64'h7700_0000_0000_0000, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_awvalid", 64'(bus.awvalid), 64'd1);
            chk("t3_awaddr", bus.awaddr, 64'h7000);
            chk("t3_wvalid", 64'(bus.wvalid), 64'(i == 0));
            if (i == 4) awready_en = 1'b1;
            @(posedge clk); #1;
        end
        wait_done(seen, err_v, dcyc);
        chk("t3_aw_count", 64'(aw_q.size()), 64'd1);
        chk("t3_w_count", 64'(wd_q.size()), 64'd1);
        chk_lines("t3", 8, 64'h7700_0000_0000_0000);

        // Outstanding limit: B withheld, fifth line waits, one B releases it next cycle
        clear_capture();
        b_hold   = 1'b1;
        outs_max = 0;
        err_at_b = -1;
        start_round(64'h8000, 64'd64);
        feed_words(40, 64'h8800_0000_0000_0000, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_awvalid", 64'(bus.awvalid), 64'd0);
            chk("t4_stall_wvalid", 64'(bus.wvalid), 64'd0);
            chk("t4_stall_aw_count", 64'(aw_q.size()), 64'd4);
            if (i == 0) b_foreign = 1'b1;
            if (i == 2) b_one = 1'b1;
            @(posedge clk); #1;
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.awvalid) begin
                found = 1'b1;
                chk("t4_release_cycle", 64'(cyc_cnt), 64'(last_b_cyc + 1));
                chk("t4_release_wvalid", 64'(bus.wvalid), 64'd1);
                chk("t4_release_addr", bus.awaddr, 64'h8100);
                b_hold = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("t4_released", 64'(found), 64'd1);
        feed_words(24, 64'h8800_0000_0000_0000, 40);
        wait_done(seen, err_v, dcyc);
        chk("t4_aw_count", 64'(aw_q.size()), 64'd8);
        chk("t4_outs_max", 64'(outs_max), 64'd4);
        chk("t4_err", 64'(err_v), 64'd0);
        chk_lines("t4", 64, 64'h8800_0000_0000_0000);

        // Reset in the middle of a line with two lines awaiting B
        clear_capture();
        b_hold = 1'b1;
        start_round(64'h9000, 64'd24);
        feed_words(20, 64'h9900_0000_0000_0000, 0);
        @(negedge clk);
        chk("t6_outstanding_lines", 64'(aw_q.size()), 64'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_reset_outputs", 64'({bus.in_ready, bus.awvalid, bus.wvalid, busy, done, err, bus.bready}),
            64'(7'b0000001));
        err_at_b = b_cnt;
        b_hold   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t6_idle_after_reset", 64'({done, busy, err, bus.awvalid}), 64'd0);
        end
        @(posedge clk); #1;
        chk("t6_stray_b_sent", 64'(b_pend), 64'd0);
        run_row(post_rst, 64'hAA00_0000_0000_0000, "t6_new_round");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
